ahb_busreq_ctrl: RTL

AHB_BUSREQ_CTRL -- requirements
Module: ahb_busreq_ctrl

---
 rtl/ahb_busreq_ctrl_pkg.sv | 40 ++++
 rtl/ahb_busreq_ctrl_if.sv | 28 ++
 rtl/ahb_busreq_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ahb_busreq_ctrl_pkg.sv
// Shared AHB encodings, FSM state type and small helpers for the burst request controller.
package ahb_pkg;

    localparam int MAX_LEN_DEF = 16;
    localparam int LEN_W       = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ADDR = 3'd2,
        ST_LAST = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                    input logic [LEN_W-1:0] max_len);
        return (len != '0) && (len <= max_len);
    endfunction

    // A retried beat goes back on the remaining count, never beyond a full burst.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v,
                                                 input logic [LEN_W-1:0] max_len);
        return (v >= max_len) ? max_len : v + {{(LEN_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ahb_busreq_ctrl_if.sv
// User request handshake plus AHB master-side bus signals of the burst request controller.
interface ahb_busreq_ctrl_if;

    logic       i_req_valid;
    logic [4:0] i_req_len;
    logic       o_req_ready;

    logic       o_hbusreq;
    logic       i_hgrant;
    logic       i_hready;
    logic [1:0] i_hresp;
    logic [1:0] o_htrans;

    logic       o_beat;
    logic       o_done;
    logic       o_err;

    modport master (
        input  i_req_valid, i_req_len, i_hgrant, i_hready, i_hresp,
        output o_req_ready, o_hbusreq, o_htrans, o_beat, o_done, o_err
    );

    modport slave (
        output i_req_valid, i_req_len, i_hgrant, i_hready, i_hresp,
        input  o_req_ready, o_hbusreq, o_htrans, o_beat, o_done, o_err
    );

endinterface

// File: rtl/ahb_busreq_ctrl.sv
// AHB master burst sequencer: requests the bus, issues NONSEQ/SEQ addresses, tracks data
// phases and recovers from grant loss, RETRY/SPLIT and ERROR responses.
import ahb_pkg::*;

module ahb_busreq_ctrl #(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               i_hclk,
    input  logic               i_hreset,
    ahb_busreq_ctrl_if.master  bus
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              dph_q, dph_d;
    logic              hbusreq_q, hbusreq_d;
    htrans_e           htrans_q, htrans_d;
    logic              beat_q, beat_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;

    logic              resp_err;
    logic              resp_retry;

    // First cycle of a two-cycle response only counts while one of our data phases is open.
    always_comb begin
        resp_err   = dph_q && !bus.i_hready && (bus.i_hresp == HRESP_ERROR);
        resp_retry = dph_q && !bus.i_hready &&
                     ((bus.i_hresp == HRESP_RETRY) || (bus.i_hresp == HRESP_SPLIT));
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dph_d   = dph_q;

        if (bus.i_hready) begin
            dph_d = (state_q == ST_ADDR);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req_valid && len_ok(bus.i_req_len, MAX_LEN_C)) begin
                    state_d = ST_REQ;
                    rem_d   = bus.i_req_len;
                end
            end
            ST_REQ: begin
                if (resp_err) begin
                    state_d = ST_ERR;
                end else if (resp_retry) begin
                    rem_d = sat_inc(rem_q, MAX_LEN_C);
                end else if (bus.i_hgrant && bus.i_hready) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (resp_err) begin
                    state_d = ST_ERR;
                end else if (resp_retry) begin
                    state_d = ST_REQ;
                    rem_d   = sat_inc(rem_q, MAX_LEN_C);
                end else if (bus.i_hready) begin
                    rem_d = rem_q - ONE_C;
                    if (rem_q == ONE_C) begin
                        state_d = ST_LAST;
                    end else if (!bus.i_hgrant) begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_LAST: begin
                if (resp_err) begin
                    state_d = ST_ERR;
                end else if (resp_retry) begin
                    state_d = ST_REQ;
                    rem_d   = sat_inc(rem_q, MAX_LEN_C);
                end else if (bus.i_hready && (bus.i_hresp == HRESP_OKAY)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (bus.i_hready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they appear registered with it.
    always_comb begin
        hbusreq_d   = (state_d == ST_REQ) || ((state_d == ST_ADDR) && (rem_d > ONE_C));
        req_ready_d = (state_d == ST_IDLE);
        beat_d      = dph_q && bus.i_hready && (bus.i_hresp == HRESP_OKAY);
        done_d      = (state_q == ST_LAST) && (state_d == ST_IDLE);
        err_d       = (state_q == ST_ERR)  && (state_d == ST_IDLE);

        htrans_d = HTRANS_IDLE;
        if (state_d == ST_ADDR) begin
            if (state_q != ST_ADDR) begin
                htrans_d = HTRANS_NONSEQ;
            end else if (bus.i_hready) begin
                htrans_d = HTRANS_SEQ;
            end else begin
                htrans_d = htrans_q;
            end
        end
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            dph_q       <= 1'b0;
            hbusreq_q   <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            beat_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            dph_q       <= dph_d;
            hbusreq_q   <= hbusreq_d;
            htrans_q    <= htrans_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_hbusreq   = hbusreq_q;
    assign bus.o_htrans    = htrans_q;
    assign bus.o_beat      = beat_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;

    a_done_err_excl: assert property (@(posedge i_hclk) disable iff (i_hreset)
        !(done_q && err_q));

endmodule
